// File: rtl/accel_pkg.sv
`default_nettype none
// accel_pkg: state encodings and derived-size helpers shared by the pass scheduler.
// Revision: 1.0
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROGRAM = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } top_state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

  function automatic int packet_length(input int tag_length, input int bitwidth);
    return 2 * tag_length + bitwidth;
  endfunction

  function automatic int scan_len(input int pe_y_size, input int pe_x_size);
    return pe_y_size + pe_y_size * pe_x_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/glb_pass_scheduler_if.sv
`default_nettype none
// glb_pass_scheduler_if: one GLB read port plus its GIN packet handshake.
// Revision: 1.0
interface glb_pass_scheduler_if
  import accel_pkg::*;
#(
  parameter int BITWIDTH        = 16,
  parameter int GLB_ADDR_LENGTH = 3,
  parameter int PACKET_LENGTH   = packet_length(4, 16)
);
  logic [GLB_ADDR_LENGTH-1:0] glb_addr;
  logic                       glb_cs;
  logic                       glb_oe;
  logic                       glb_we;
  logic [BITWIDTH-1:0]        glb_data;
  logic                       gin_enable;
  logic                       gin_ready;
  logic [PACKET_LENGTH-1:0]   packet;

  modport master (
    output glb_addr, glb_cs, glb_oe, glb_we, gin_enable, packet,
    input  glb_data, gin_ready
  );

  modport slave (
    input  glb_addr, glb_cs, glb_oe, glb_we, gin_enable, packet,
    output glb_data, gin_ready
  );
endinterface
`default_nettype wire

// File: rtl/glb_stream_reader.sv
`default_nettype none
// glb_stream_reader: reads len GLB words and offers each as a tagged GIN packet.
// Revision: 1.0
module glb_stream_reader
  import accel_pkg::*;
#(
  parameter int BITWIDTH        = 16,
  parameter int GLB_ADDR_LENGTH = 3,
  parameter int TAG_LENGTH      = 4,
  parameter int PE_Y_SIZE       = 3,
  parameter int PE_X_SIZE       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go_i,
  input  logic [GLB_ADDR_LENGTH:0]   len_i,
  output logic                       fin_next_o,
  glb_pass_scheduler_if.master       bus
);
  localparam int PACKET_LENGTH = packet_length(TAG_LENGTH, BITWIDTH);
  localparam int IDX_W         = GLB_ADDR_LENGTH + 1;

  rd_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_inc;
  logic [TAG_LENGTH-1:0]    row_q, col_q;
  logic [PACKET_LENGTH-1:0] packet_q, packet_live;
  logic                     accept;

  assign idx_inc     = idx_q + IDX_W'(1);
  assign packet_live = {row_q, col_q, bus.glb_data};
  assign accept      = ((state_q == LOAD) || (state_q == HOLD)) && bus.gin_ready;
  assign fin_next_o  = (state_d == FIN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FIN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:      state_d = LOAD;
      LOAD, HOLD: if (bus.gin_ready) state_d = (idx_inc < len_i) ? FETCH : FIN;
                  else               state_d = HOLD;
      FIN:        state_d = FIN;
      default:    state_d = FIN;
    endcase
    if (go_i) state_d = (len_i == '0) ? FIN : FETCH;
  end

  // GLB data is only valid in LOAD, so HOLD replays the copy taken there.
  always_comb begin
    bus.glb_cs     = (state_q == FETCH);
    bus.glb_oe     = (state_q == FETCH);
    bus.glb_we     = 1'b0;
    bus.glb_addr   = idx_q[GLB_ADDR_LENGTH-1:0];
    bus.gin_enable = (state_q == LOAD) || (state_q == HOLD);
    bus.packet     = (state_q == LOAD) ? packet_live : packet_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      packet_q <= '0;
    end else if (go_i) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      if (state_q == LOAD) packet_q <= packet_live;
      if (accept) begin
        idx_q <= idx_inc;
        if (col_q == TAG_LENGTH'(PE_X_SIZE - 1)) begin
          col_q <= '0;
          row_q <= (row_q == TAG_LENGTH'(PE_Y_SIZE - 1)) ? '0 : row_q + TAG_LENGTH'(1);
        end else begin
          col_q <= col_q + TAG_LENGTH'(1);
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/glb_pass_scheduler.sv
`default_nettype none
// glb_pass_scheduler: program GIN tags, stream both GLBs, drain, latch top-row psums.
// Optional GLB_PASS_SCHEDULER_PERF_EN adds a saturating stall_cycles_o counter. Revision: 1.0
module glb_pass_scheduler
  import accel_pkg::*;
#(
  parameter int  BITWIDTH        = 16,
  parameter int  GLB_ADDR_LENGTH = 3,
  parameter int  TAG_LENGTH      = 4,
  parameter int  PE_Y_SIZE       = 3,
  parameter int  PE_X_SIZE       = 3,
  parameter int  DRAIN_CYCLES    = 4,
  localparam int SCAN_LEN        = scan_len(PE_Y_SIZE, PE_X_SIZE),
  localparam int TAG_ADDR_W      = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1,
  localparam int OFMAP_W         = BITWIDTH * PE_X_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [GLB_ADDR_LENGTH:0] len_ifmap_i,
  input  logic [GLB_ADDR_LENGTH:0] len_filter_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [TAG_ADDR_W-1:0]    tag_addr_o,
  input  logic [TAG_LENGTH-1:0]    tag_ifmap_i,
  input  logic [TAG_LENGTH-1:0]    tag_filter_i,
  output logic                     program_o,
  output logic [TAG_LENGTH-1:0]    scan_tag_ifmap_o,
  output logic [TAG_LENGTH-1:0]    scan_tag_filter_o,
  glb_pass_scheduler_if.master     ifmap_if,
  glb_pass_scheduler_if.master     filter_if,
  input  logic [OFMAP_W-1:0]       ofmap_in_i,
  output logic [OFMAP_W-1:0]       ofmap_o,
`ifdef GLB_PASS_SCHEDULER_PERF_EN
  output logic [15:0]              stall_cycles_o,
`endif
  output logic                     ofmap_valid_o
);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  top_state_e                 state_q, state_d;
  logic [TAG_ADDR_W-1:0]      tag_addr_q;
  logic [DRAIN_W-1:0]         drain_q;
  logic [GLB_ADDR_LENGTH:0]   len_ifmap_q, len_filter_q;
  logic                       done_q, ofmap_valid_q;
  logic [OFMAP_W-1:0]         ofmap_q;
  logic                       tag_last, drain_last, start_acc, go;
  logic                       fin_ifmap, fin_filter;

  assign tag_last   = (tag_addr_q == TAG_ADDR_W'(SCAN_LEN - 1));
  assign drain_last = (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));
  assign start_acc  = (state_q == IDLE) && start_i;
  assign go         = (state_q == PROGRAM) && tag_last;

  glb_stream_reader #(
    .BITWIDTH(BITWIDTH), .GLB_ADDR_LENGTH(GLB_ADDR_LENGTH), .TAG_LENGTH(TAG_LENGTH),
    .PE_Y_SIZE(PE_Y_SIZE), .PE_X_SIZE(PE_X_SIZE)
  ) u_rd_ifmap (
    .clk(clk), .rst(rst), .go_i(go), .len_i(len_ifmap_q),
    .fin_next_o(fin_ifmap), .bus(ifmap_if)
  );

  glb_stream_reader #(
    .BITWIDTH(BITWIDTH), .GLB_ADDR_LENGTH(GLB_ADDR_LENGTH), .TAG_LENGTH(TAG_LENGTH),
    .PE_Y_SIZE(PE_Y_SIZE), .PE_X_SIZE(PE_X_SIZE)
  ) u_rd_filter (
    .clk(clk), .rst(rst), .go_i(go), .len_i(len_filter_q),
    .fin_next_o(fin_filter), .bus(filter_if)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Readers report their next state so DRAIN starts right after the last accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = PROGRAM;
      PROGRAM: if (tag_last) state_d = STREAM;
      STREAM:  if (fin_ifmap && fin_filter) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o            = (state_q != IDLE);
    program_o         = (state_q == PROGRAM);
    scan_tag_ifmap_o  = program_o ? tag_ifmap_i  : '0;
    scan_tag_filter_o = program_o ? tag_filter_i : '0;
    tag_addr_o        = tag_addr_q;
    done_o            = done_q;
    ofmap_o           = ofmap_q;
    ofmap_valid_o     = ofmap_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_addr_q    <= '0;
      drain_q       <= '0;
      len_ifmap_q   <= '0;
      len_filter_q  <= '0;
      done_q        <= 1'b0;
      ofmap_q       <= '0;
      ofmap_valid_q <= 1'b0;
    end else begin
      done_q     <= (state_q == CAPTURE);
      tag_addr_q <= ((state_q == PROGRAM) && !tag_last) ? tag_addr_q + TAG_ADDR_W'(1) : '0;
      drain_q    <= ((state_q == DRAIN) && !drain_last) ? drain_q + DRAIN_W'(1) : '0;
      if (start_acc) begin
        len_ifmap_q   <= len_ifmap_i;
        len_filter_q  <= len_filter_i;
        ofmap_valid_q <= 1'b0;
      end
      if (state_q == CAPTURE) begin
        ofmap_q       <= ofmap_in_i;
        ofmap_valid_q <= 1'b1;
      end
    end
  end

`ifdef GLB_PASS_SCHEDULER_PERF_EN
  logic [15:0] stall_cycles_q;
  logic        stall_now;

  assign stall_now = (state_q == STREAM) &&
                     ((ifmap_if.gin_enable && !ifmap_if.gin_ready) ||
                      (filter_if.gin_enable && !filter_if.gin_ready));

  always_ff @(posedge clk) begin
    if (rst || start_acc)                          stall_cycles_q <= '0;
    else if (stall_now && (stall_cycles_q != '1))  stall_cycles_q <= stall_cycles_q + 16'd1;
  end

  assign stall_cycles_o = stall_cycles_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_glb_pass_scheduler.sv
`default_nettype none
// tb_glb_pass_scheduler: scoreboard bench for glb_pass_scheduler with GLB models and GIN sinks.
// Revision: 1.0
module tb_glb_pass_scheduler;
  localparam int BW   = 16;
  localparam int AW   = 3;
  localparam int TL   = 4;
  localparam int PY   = 3;
  localparam int PX   = 3;
  localparam int DR   = 4;
  localparam int PL   = 2 * TL + BW;
  localparam int SCAN = PY + PY * PX;
  localparam int OW   = BW * PX;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [AW:0]   len_if, len_f;
  logic          busy, done, prog, ofmap_valid;
  logic [3:0]    tag_addr;
  logic [TL-1:0] tag_if, tag_f, stag_if, stag_f;
  logic [OW-1:0] ofmap_in, ofmap;
`ifdef GLB_PASS_SCHEDULER_PERF_EN
  logic [15:0]   stall_cycles;
`endif
  logic [BW-1:0] gdata_if, gdata_f;
  logic          rdy_if = 1'b1, rdy_f = 1'b1;
  logic [BW-1:0] mem_if [0:7];
  logic [BW-1:0] mem_f  [0:7];
  logic [PL-1:0] exp_if [$];
  logic [PL-1:0] exp_f  [$];

  int n_total = 0, n_bad = 0, cyc = 0;
  int acc_if, acc_f, cs_if, cs_f, prog_cnt, prog_first, done_cnt, done_cyc, last_acc;
  int stall_idx = -1, stall_left = 0;
  bit done_seen;

  glb_pass_scheduler_if #(.BITWIDTH(BW), .GLB_ADDR_LENGTH(AW), .PACKET_LENGTH(PL)) if_ifmap ();
  glb_pass_scheduler_if #(.BITWIDTH(BW), .GLB_ADDR_LENGTH(AW), .PACKET_LENGTH(PL)) if_filter ();

  assign if_ifmap.glb_data  = gdata_if;
  assign if_ifmap.gin_ready = rdy_if;
  assign if_filter.glb_data  = gdata_f;
  assign if_filter.gin_ready = rdy_f;
  assign tag_if = tag_addr;
  assign tag_f  = 4'd15 - tag_addr;

  glb_pass_scheduler #(
    .BITWIDTH(BW), .GLB_ADDR_LENGTH(AW), .TAG_LENGTH(TL),
    .PE_Y_SIZE(PY), .PE_X_SIZE(PX), .DRAIN_CYCLES(DR)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start),
    .len_ifmap_i(len_if), .len_filter_i(len_f),
    .busy_o(busy), .done_o(done), .tag_addr_o(tag_addr),
    .tag_ifmap_i(tag_if), .tag_filter_i(tag_f), .program_o(prog),
    .scan_tag_ifmap_o(stag_if), .scan_tag_filter_o(stag_f),
    .ifmap_if(if_ifmap), .filter_if(if_filter),
    .ofmap_in_i(ofmap_in), .ofmap_o(ofmap),
`ifdef GLB_PASS_SCHEDULER_PERF_EN
    .stall_cycles_o(stall_cycles),
`endif
    .ofmap_valid_o(ofmap_valid)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if_ifmap.glb_cs && if_ifmap.glb_oe)   gdata_if <= mem_if[if_ifmap.glb_addr];
    if (if_filter.glb_cs && if_filter.glb_oe) gdata_f  <= mem_f[if_filter.glb_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [PL-1:0] exp_pkt(input int k, input logic [BW-1:0] d);
    return {TL'((k / PX) % PY), TL'(k % PX), d};
  endfunction

  // GIN sinks: drive ready, compare offered packets, pop on accept.
  initial begin
    forever begin
      @(negedge clk);
      rdy_if = 1'b1;
      rdy_f  = 1'b1;
      if (!rst) begin
        if (if_ifmap.gin_enable) begin
          if (acc_if == stall_idx && stall_left > 0) begin
            rdy_if = 1'b0;
            stall_left--;
          end
          if (exp_if.size() == 0) check("ifmap_extra_pkt", 1, 0);
          else begin
            check("ifmap_pkt", if_ifmap.packet, exp_if[0]);
            if (rdy_if) begin
              void'(exp_if.pop_front());
              acc_if++;
              last_acc = cyc;
            end
          end
        end
        if (if_filter.gin_enable) begin
          if (exp_f.size() == 0) check("filter_extra_pkt", 1, 0);
          else begin
            check("filter_pkt", if_filter.packet, exp_f[0]);
            void'(exp_f.pop_front());
            acc_f++;
            last_acc = cyc;
          end
        end
        if (if_ifmap.glb_cs && if_ifmap.glb_oe)   cs_if++;
        if (if_filter.glb_cs && if_filter.glb_oe) cs_f++;
        if (prog) begin
          check("tag_addr", tag_addr, prog_cnt);
          check("scan_ifmap", stag_if, prog_cnt);
          check("scan_filter", stag_f, 15 - prog_cnt);
          if (prog_cnt == 0) prog_first = cyc;
          prog_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc  = cyc;
          done_seen = 1'b1;
        end
      end
    end
  end

  task automatic run_pass(input int li, input int lf, input int si, input int sl,
                          input bit rnd, input bit abort);
    int s, m, exp_done;
    logic [OW-1:0] oin;
    for (int k = 0; k < 8; k++) begin
      mem_if[k] = rnd ? BW'($urandom) : BW'(k + 1);
      mem_f[k]  = rnd ? BW'($urandom) : BW'(k + 1);
    end
    for (int k = 0; k < li; k++) exp_if.push_back(exp_pkt(k, mem_if[k]));
    for (int k = 0; k < lf; k++) exp_f.push_back(exp_pkt(k, mem_f[k]));
    acc_if = 0; acc_f = 0; cs_if = 0; cs_f = 0; prog_cnt = 0; prog_first = -1;
    done_cnt = 0; done_cyc = -1; last_acc = -1; done_seen = 1'b0;
    stall_idx = si; stall_left = sl;
    oin = OW'({$urandom, $urandom});
    ofmap_in = oin;
    @(negedge clk);
    start = 1'b1; len_if = (AW+1)'(li); len_f = (AW+1)'(lf); s = cyc;
    @(negedge clk);
    start = 1'b0;
    len_if = (AW+1)'($urandom_range(1, 8));
    len_f  = (AW+1)'($urandom_range(1, 8));
    check("busy_after_start", busy, 1);
    check("valid_cleared", ofmap_valid, 0);
    if (abort) begin
      for (int i = 0; i < 200 && acc_if < 2; i++) @(negedge clk);
      check("abort_reached_stream", (acc_if >= 2), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_ofmap", {ofmap_valid, ofmap}, 0);
      check("abort_enables", {if_ifmap.gin_enable, if_filter.gin_enable,
                              if_ifmap.glb_cs, if_filter.glb_cs}, 0);
      check("abort_pkts", {if_ifmap.packet, if_filter.packet, if_ifmap.glb_addr}, 0);
      exp_if.delete();
      exp_f.delete();
      stall_left = 0;
      return;
    end
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) @(negedge clk);
    check("done_timeout", done_seen, 1);
    repeat (2) @(negedge clk);
    m = (2 * li + sl > 2 * lf) ? 2 * li + sl : 2 * lf;
    exp_done = (m == 0) ? s + SCAN + DR + 3 : s + SCAN + m + DR + 2;
    check("done_cycle", done_cyc - s, exp_done - s);
    if (m > 0) check("accept_to_done", done_cyc - last_acc, DR + 2);
    check("done_pulse_len", done_cnt, 1);
    check("program_cycles", prog_cnt, SCAN);
    check("program_first", prog_first - s, 1);
    check("ifmap_left", exp_if.size(), 0);
    check("filter_left", exp_f.size(), 0);
    check("ifmap_glb_reads", cs_if, li);
    check("filter_glb_reads", cs_f, lf);
    check("ofmap", ofmap, oin);
    check("ofmap_valid", ofmap_valid, 1);
    check("idle_busy", busy, 0);
`ifdef GLB_PASS_SCHEDULER_PERF_EN
    check("stall_cycles", stall_cycles, sl);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len_if = '0; len_f = '0;
    ofmap_in = OW'({$urandom, $urandom});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ctl", {busy, done, prog, ofmap_valid}, 0);
    check("rst_tags", {tag_addr, stag_if, stag_f}, 0);
    check("rst_ofmap", ofmap, 0);
    check("rst_glb", {if_ifmap.glb_cs, if_ifmap.glb_oe, if_ifmap.glb_we, if_ifmap.glb_addr,
                      if_filter.glb_cs, if_filter.glb_oe, if_filter.glb_we, if_filter.glb_addr}, 0);
    check("rst_gin", {if_ifmap.gin_enable, if_filter.gin_enable}, 0);
    check("rst_pkts", {if_ifmap.packet, if_filter.packet}, 0);

    run_pass(4, 2, -1, 0, 1'b0, 1'b0);
    run_pass(4, 2, 2, 3, 1'b0, 1'b0);
    run_pass(0, 0, -1, 0, 1'b0, 1'b0);
    run_pass(8, 7, -1, 0, 1'b1, 1'b0);
    run_pass(3, 8, 0, 2, 1'b1, 1'b0);
    run_pass(5, 3, -1, 0, 1'b0, 1'b1);
    run_pass(5, 3, -1, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
